// File: rtl/sram_tester_pkg.sv
// Shared constants for the SRAM tester slice: bus widths, FSM encoding and the
// read latency the controller's wait-state setting is matched against.
package sram_tester_pkg;

  localparam int SRAM_AW          = 21;
  localparam int SRAM_DW          = 8;
  localparam int DEFAULT_READ_LAT = 2;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE       = 2'd0;
  localparam state_t ST_WRITE_OPEN = 2'd1;
  localparam state_t ST_READ_WAIT  = 2'd2;
  localparam state_t ST_READ_DRIVE = 2'd3;

endpackage

// File: rtl/sram_bram_1rw.sv
// Single-port byte RAM with registered (read-first) output and a write strobe;
// shaped so synthesis maps it onto MAX10 M9K blocks.
module sram_bram_1rw #(
  parameter int AW = 15,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/sram_bram_responder.sv
// Block-RAM backed responder for the 8-bit async SRAM pin interface: commits
// writes at the end of the pulse and drives reads only after the access latency.
module sram_bram_responder
  import sram_tester_pkg::*;
#(
  parameter int AW       = SRAM_AW,
  parameter int MEM_AW   = 15,
  parameter int READ_LAT = DEFAULT_READ_LAT,
  parameter int CNT_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [AW-1:0]      sram_a,
  inout  wire  [SRAM_DW-1:0] sram_dq,
  input  logic               sram_nce,
  input  logic               sram_noe,
  input  logic               sram_nwe,
  output logic [CNT_W-1:0]   wr_count,
  output logic [CNT_W-1:0]   rd_count,
  output logic               oor_seen,
  output logic               contention,
  output logic               busy
);

  localparam int LW = (READ_LAT > 2) ? $clog2(READ_LAT) : 1;
  localparam logic [LW-1:0] LAT_LAST = LW'((READ_LAT >= 2) ? READ_LAT - 2 : 0);
  // With a one-cycle latency the BRAM read issued on capture is already enough.
  localparam bit DIRECT = (READ_LAT <= 1);

  function automatic logic addr_oor(input logic [AW-1:0] a);
    return |(a >> MEM_AW);
  endfunction

  logic [AW-1:0]      r_a;
  logic [SRAM_DW-1:0] r_dq;
  logic               r_nce, r_noe, r_nwe;

  state_t              state, state_n;
  logic [LW-1:0]       lat_cnt, cnt_n;
  logic [AW-1:0]       cap_a;
  logic [MEM_AW-1:0]   pend_a;
  logic [SRAM_DW-1:0]  pend_d;
  logic                armed;
  logic                capture, latch_w, commit, enter_drive;
  logic                rd_cond, wr_cond, addr_same, dq_oe;
  logic                bram_we;
  logic [MEM_AW-1:0]   bram_addr;
  logic [SRAM_DW-1:0]  bram_rdata;

  // Input stage: every pin registered once, decisions use r_* only
  always_ff @(posedge clk) begin
    r_a   <= sram_a;
    r_dq  <= sram_dq;
    r_nce <= sram_nce;
    r_noe <= sram_noe;
    r_nwe <= sram_nwe;
  end

  assign rd_cond   = !r_nce && !r_noe && r_nwe;
  assign wr_cond   = !r_nce && !r_nwe;
  assign addr_same = (r_a == cap_a);

  always_comb begin
    state_n     = state;
    cnt_n       = lat_cnt;
    capture     = 1'b0;
    latch_w     = 1'b0;
    commit      = 1'b0;
    case (state)
      ST_IDLE: begin
        // armed blocks a write pulse that was already low when reset released
        if (wr_cond && armed) begin
          state_n = ST_WRITE_OPEN;
          latch_w = 1'b1;
        end else if (rd_cond) begin
          capture = 1'b1;
          cnt_n   = '0;
          state_n = DIRECT ? ST_READ_DRIVE : ST_READ_WAIT;
        end
      end
      ST_WRITE_OPEN: begin
        if (wr_cond) begin
          latch_w = 1'b1;
        end else begin
          commit = 1'b1;
          if (rd_cond) begin
            capture = 1'b1;
            cnt_n   = '0;
            state_n = ST_READ_WAIT;
          end else begin
            state_n = ST_IDLE;
          end
        end
      end
      ST_READ_WAIT, ST_READ_DRIVE: begin
        if (r_nce) begin
          state_n = ST_IDLE;
        end else if (!r_nwe) begin
          state_n = ST_WRITE_OPEN;
          latch_w = 1'b1;
        end else if (r_noe) begin
          state_n = ST_IDLE;
        end else if (!addr_same) begin
          capture = 1'b1;
          cnt_n   = '0;
          state_n = DIRECT ? ST_READ_DRIVE : ST_READ_WAIT;
        end else if (state == ST_READ_WAIT) begin
          if (lat_cnt == LAT_LAST) state_n = ST_READ_DRIVE;
          else                     cnt_n   = lat_cnt + 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    enter_drive = (state_n == ST_READ_DRIVE) && ((state != ST_READ_DRIVE) || capture);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      lat_cnt    <= '0;
      wr_count   <= '0;
      rd_count   <= '0;
      oor_seen   <= 1'b0;
      contention <= 1'b0;
      armed      <= 1'b0;
    end else begin
      state   <= state_n;
      lat_cnt <= cnt_n;
      if (commit)      wr_count <= wr_count + 1'b1;
      if (enter_drive) rd_count <= rd_count + 1'b1;
      if ((capture || latch_w) && addr_oor(r_a)) oor_seen <= 1'b1;
      if (!r_nce && !r_noe && !r_nwe)            contention <= 1'b1;
      if (r_nwe || r_nce)                        armed <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) cap_a <= r_a;
    if (latch_w) begin
      pend_a <= r_a[MEM_AW-1:0];
      pend_d <= r_dq;
    end
  end

  // The single port is stolen for the commit; reads follow r_a otherwise
  assign bram_we   = commit && !reset;
  assign bram_addr = bram_we ? pend_a : r_a[MEM_AW-1:0];

  sram_bram_1rw #(
    .AW (MEM_AW),
    .DW (SRAM_DW)
  ) u_ram (
    .clk   (clk),
    .we    (bram_we),
    .addr  (bram_addr),
    .wdata (pend_d),
    .rdata (bram_rdata)
  );

  // Drop the bus the moment the registered pins stop describing this read
  assign dq_oe   = (state == ST_READ_DRIVE) && rd_cond && addr_same;
  assign sram_dq = dq_oe ? bram_rdata : {SRAM_DW{1'bz}};
  assign busy    = (state != ST_IDLE);

endmodule

// File: tb/tb_sram_bram_responder.sv
// Scoreboard bench for sram_bram_responder: directed SRAM pin sequences push
// expected commits and read data; a negedge monitor pops and compares them.
module tb_sram_bram_responder;
  import sram_tester_pkg::*;

  localparam int AW       = 21;
  localparam int MEM_AW   = 15;
  localparam int READ_LAT = 2;
  localparam int CNT_W    = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [AW-1:0]     sram_a;
  wire  [7:0]        sram_dq;
  logic              sram_nce, sram_noe, sram_nwe;
  logic [CNT_W-1:0]  wr_count, rd_count;
  logic              oor_seen, contention, busy;
  logic [7:0]        tb_dq;
  logic              tb_dq_en;

  assign sram_dq = tb_dq_en ? tb_dq : 8'bz;

  sram_bram_responder #(
    .AW(AW), .MEM_AW(MEM_AW), .READ_LAT(READ_LAT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .sram_a(sram_a), .sram_dq(sram_dq),
    .sram_nce(sram_nce), .sram_noe(sram_noe), .sram_nwe(sram_nwe),
    .wr_count(wr_count), .rd_count(rd_count), .oor_seen(oor_seen),
    .contention(contention), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  logic rst_q = 1'b1;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= reset;
  end

  typedef struct {
    string      name;
    logic [7:0] data;
    int         cnt;
    int         cycle;
  } exp_t;

  exp_t rq[$];
  exp_t wq[$];
  int tests = 0, fails = 0;
  int wr_total = 0, rd_total = 0;
  int clash = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: a read completes when the DUT starts driving, a write when wr_count moves
  logic             prev_oe = 1'b0;
  logic [CNT_W-1:0] prev_wr = '0;
  exp_t             me;
  always @(negedge clk) begin
    if (reset || rst_q) begin
      prev_oe = 1'b0;
      prev_wr = wr_count;
    end else begin
      if (dut.dq_oe && tb_dq_en) clash++;
      if (dut.dq_oe && !prev_oe) begin
        if (rq.size() == 0) begin
          chk("unexpected_read_drive", 32'(sram_dq), 32'hFFFF_FFFF);
        end else begin
          me = rq.pop_front();
          chk({me.name, "_data"}, 32'(sram_dq), 32'(me.data));
          chk({me.name, "_cycle"}, 32'(cyc), 32'(me.cycle));
          chk({me.name, "_rd_count"}, 32'(rd_count), 32'(me.cnt));
        end
      end
      if (wr_count != prev_wr) begin
        if (wq.size() == 0) begin
          chk("unexpected_commit", 32'(wr_count), 32'(prev_wr));
        end else begin
          me = wq.pop_front();
          chk({me.name, "_wr_count"}, 32'(wr_count), 32'(me.cnt));
          chk({me.name, "_cycle"}, 32'(cyc), 32'(me.cycle));
        end
      end
      prev_oe = dut.dq_oe;
      prev_wr = wr_count;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    sram_nce = 1'b1;
    sram_noe = 1'b1;
    sram_nwe = 1'b1;
    tb_dq_en = 1'b0;
  endtask

  // Write pulse: d0 for n0 cycles then d1 for n1 cycles; oe_low makes it a contention write
  task automatic do_write(input string name, input logic [AW-1:0] addr,
                          input logic [7:0] d0, input logic [7:0] d1,
                          input int n0, input int n1, input bit oe_low);
    exp_t e;
    sram_a   = addr;
    sram_nce = 1'b0;
    sram_nwe = 1'b0;
    sram_noe = !oe_low;
    tb_dq    = d0;
    tb_dq_en = 1'b1;
    repeat (n0) tick();
    tb_dq = d1;
    repeat (n1) tick();
    if (n0 + n1 >= 2) chk({name, "_busy"}, 32'(busy), 32'd1);
    wr_total++;
    e.name = name; e.data = d1; e.cnt = wr_total; e.cycle = cyc + 2;
    wq.push_back(e);
    idle_bus();
    repeat (4) tick();
  endtask

  // Read; with sw set the address moves to addr2 one cycle after the read starts
  task automatic do_read(input string name, input logic [AW-1:0] addr,
                         input bit sw, input logic [AW-1:0] addr2, input logic [7:0] data);
    exp_t e;
    sram_a   = addr;
    sram_nce = 1'b0;
    sram_noe = 1'b0;
    sram_nwe = 1'b1;
    tb_dq_en = 1'b0;
    if (sw) begin
      tick();
      sram_a = addr2;
    end
    rd_total++;
    e.name = name; e.data = data; e.cnt = rd_total; e.cycle = cyc + READ_LAT + 1;
    rq.push_back(e);
    repeat (READ_LAT + 2) tick();
    idle_bus();
    repeat (3) tick();
  endtask

  initial begin
    reset  = 1'b1;
    sram_a = '0;
    tb_dq  = '0;
    idle_bus();
    repeat (3) tick();
    reset = 1'b0;
    repeat (2) tick();

    chk("rst_wr_count", 32'(wr_count), 32'd0);
    chk("rst_rd_count", 32'(rd_count), 32'd0);
    chk("rst_oor_seen", 32'(oor_seen), 32'd0);
    chk("rst_contention", 32'(contention), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_dq_idle", 32'(dut.dq_oe), 32'd0);

    do_write("wr10", 21'h00010, 8'hA5, 8'hA5, 3, 0, 1'b0);
    do_read("rd10", 21'h00010, 1'b0, 21'h0, 8'hA5);

    do_write("wr05", 21'h00005, 8'h11, 8'h22, 1, 1, 1'b0);
    do_read("rd05", 21'h00005, 1'b0, 21'h0, 8'h22);

    do_write("wr01", 21'h00001, 8'h3C, 8'h3C, 1, 0, 1'b0);
    do_write("wr02", 21'h00002, 8'hC3, 8'hC3, 2, 0, 1'b0);
    do_read("rd_switch", 21'h00001, 1'b1, 21'h00002, 8'hC3);

    chk("oor_before", 32'(oor_seen), 32'd0);
    do_write("wr_alias", 21'h08003, 8'h77, 8'h77, 2, 0, 1'b0);
    chk("oor_after", 32'(oor_seen), 32'd1);
    do_read("rd_alias", 21'h00003, 1'b0, 21'h0, 8'h77);

    chk("cont_before", 32'(contention), 32'd0);
    do_write("wr_cont", 21'h00007, 8'h5A, 8'h5A, 2, 0, 1'b1);
    chk("cont_after", 32'(contention), 32'd1);
    do_read("rd_cont", 21'h00007, 1'b0, 21'h0, 8'h5A);
    chk("cont_sticky", 32'(contention), 32'd1);

    // Reset lands while a write pulse to 0x20 is open
    do_write("wr20", 21'h00020, 8'h96, 8'h96, 2, 0, 1'b0);
    sram_a   = 21'h00020;
    sram_nce = 1'b0;
    sram_nwe = 1'b0;
    tb_dq    = 8'hEE;
    tb_dq_en = 1'b1;
    repeat (2) tick();
    chk("midwr_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset    = 1'b0;
    wr_total = 0;
    rd_total = 0;
    tick();
    idle_bus();
    repeat (4) tick();
    chk("midwr_wr_count", 32'(wr_count), 32'd0);
    chk("midwr_busy_after", 32'(busy), 32'd0);
    chk("midwr_dq_idle", 32'(dut.dq_oe), 32'd0);
    chk("midwr_contention", 32'(contention), 32'd0);
    chk("midwr_oor", 32'(oor_seen), 32'd0);
    do_read("rd20", 21'h00020, 1'b0, 21'h0, 8'h96);

    for (int i = 0; i < 200 && (rq.size() != 0 || wq.size() != 0); i++) tick();
    chk("reads_drained", 32'(rq.size()), 32'd0);
    chk("writes_drained", 32'(wq.size()), 32'd0);
    chk("no_bus_clash", 32'(clash), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
